// File: rtl/lfsr_updown_param.sv
// Reversible XNOR LFSR counter with parallel load, lock-up recovery, a registered
// wrap pulse and a binary position tracker measured from the last seed/load point.
// WIDTH must be 3..32, TAPS[WIDTH-1] must be set, SEED must not be all-ones.
module lfsr_updown_param #(
    parameter int unsigned      WIDTH    = 8,
    parameter logic [WIDTH-1:0] TAPS     = WIDTH'(8'b10110001),
    parameter logic [WIDTH-1:0] SEED     = '0,
    parameter logic [WIDTH-1:0] TERM_FWD = {1'b1, {(WIDTH - 1){1'b0}}},
    parameter logic [WIDTH-1:0] TERM_REV = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] position,
    output logic             overflow,
    output logic             wrap,
    output logic             lockup
);

    // All-ones is the XNOR lock-up state; PosMax is the last position before it wraps.
    localparam logic [WIDTH-1:0] AllOnes = '1;
    localparam logic [WIDTH-1:0] PosMax  = {{(WIDTH - 1){1'b1}}, 1'b0};

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] pos_q, pos_d;
    logic             wrap_q, wrap_d;
    logic             lockup_q, lockup_d;

    logic [WIDTH-1:0] fwd_next;
    logic [WIDTH-1:0] rev_next;
    logic [WIDTH-1:0] pos_inc;
    logic [WIDTH-1:0] pos_dec;

    // Forward shifts left and appends the XNOR of the tapped bits; reverse undoes it by
    // recovering the old MSB from the appended bit and the remaining taps.
    assign fwd_next = {count_q[WIDTH-2:0], ~^(count_q & TAPS)};
    assign rev_next = {~(count_q[0] ^ (^(count_q[WIDTH-1:1] & TAPS[WIDTH-2:0]))),
                       count_q[WIDTH-1:1]};

    // Position counts modulo 2^WIDTH-1, matching the sequence period.
    assign pos_inc = (pos_q == PosMax) ? '0 : pos_q + WIDTH'(1);
    assign pos_dec = (pos_q == '0) ? PosMax : pos_q - WIDTH'(1);

    // Terminal-state detect follows the requested direction combinationally.
    always_comb begin
        overflow = up_down ? (count_q == TERM_REV) : (count_q == TERM_FWD);
    end

    // Next state: load beats enable beats hold; lock-up recovery replaces the step.
    always_comb begin
        count_d  = count_q;
        pos_d    = pos_q;
        wrap_d   = 1'b0;
        lockup_d = 1'b0;
        if (load) begin
            pos_d = '0;
            if (load_value == AllOnes) begin
                count_d  = SEED;
                lockup_d = 1'b1;
            end else begin
                count_d = load_value;
            end
        end else if (enable) begin
            if (count_q == AllOnes) begin
                count_d  = SEED;
                pos_d    = '0;
                lockup_d = 1'b1;
            end else begin
                wrap_d = overflow;
                if (up_down) begin
                    count_d = rev_next;
                    pos_d   = pos_dec;
                end else begin
                    count_d = fwd_next;
                    pos_d   = pos_inc;
                end
            end
        end
    end

    // State and pulse registers, cleared asynchronously to the seed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q  <= SEED;
            pos_q    <= '0;
            wrap_q   <= 1'b0;
            lockup_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            pos_q    <= pos_d;
            wrap_q   <= wrap_d;
            lockup_q <= lockup_d;
        end
    end

    assign count    = count_q;
    assign position = pos_q;
    assign wrap     = wrap_q;
    assign lockup   = lockup_q;

endmodule

// File: tb/tb_lfsr_updown_param.sv
// Scoreboard bench for lfsr_updown_param: an 8-bit default instance under directed and
// random stimulus, and a 16-bit instance swept through its full period and partly back.
// The model tracks an index into a precomputed state table plus a modular position.
module tb_lfsr_updown_param;

    typedef struct packed {
        logic [15:0] count;
        logic [15:0] position;
        logic        wrap;
        logic        lockup;
        logic        overflow;
    } exp_t;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // 8-bit instance signals
    logic        reset_n8 = 1'b0, enable8 = 1'b0, up_down8 = 1'b0, load8 = 1'b0;
    logic [7:0]  load_value8 = '0;
    logic [7:0]  count8, position8;
    logic        overflow8, wrap8, lockup8;

    // 16-bit instance signals
    logic        reset_n16 = 1'b0, enable16 = 1'b0, up_down16 = 1'b0, load16 = 1'b0;
    logic [15:0] load_value16 = '0;
    logic [15:0] count16, position16;
    logic        overflow16, wrap16, lockup16;

    lfsr_updown_param u_dut8 (
        .clk(clk), .reset_n(reset_n8), .enable(enable8), .up_down(up_down8),
        .load(load8), .load_value(load_value8), .count(count8), .position(position8),
        .overflow(overflow8), .wrap(wrap8), .lockup(lockup8)
    );

    lfsr_updown_param #(
        .WIDTH(16), .TAPS(16'hB400), .SEED(16'h0000), .TERM_FWD(16'h8000), .TERM_REV(16'h0001)
    ) u_dut16 (
        .clk(clk), .reset_n(reset_n16), .enable(enable16), .up_down(up_down16),
        .load(load16), .load_value(load_value16), .count(count16), .position(position16),
        .overflow(overflow16), .wrap(wrap16), .lockup(lockup16)
    );

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void chk_v(string name, longint act, longint req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endfunction

    function automatic void chk_e(string name, exp_t act, exp_t req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s @%0t: got cnt=%h pos=%h wrap=%b lock=%b ovf=%b, required cnt=%h pos=%h wrap=%b lock=%b ovf=%b",
                      name, $time, act.count, act.position, act.wrap, act.lockup, act.overflow,
                      req.count, req.position, req.wrap, req.lockup, req.overflow);
    endfunction

    // Forward LFSR rule, used only to lay out the state table.
    function automatic logic [15:0] nxt(logic [15:0] x, logic [15:0] taps, int w);
        logic [15:0] mask;
        logic        fb;
        mask = 16'((32'd1 << w) - 1);
        fb   = ~(^(x & taps));
        return ((x << 1) | 16'(fb)) & mask;
    endfunction

    // ---------------- reference model state ----------------
    int   seq8 [0:255];
    int   idx8 [0:255];
    int   p8, abs8, pos8;
    int   seq16 [0:65535];
    int   p16, abs16, pos16;
    exp_t q8[$];
    exp_t q16[$];

    bit   track8 = 0, track16 = 0;
    bit   seen8 [0:255];
    bit   seen16 [0:65535];
    int   distinct8 = 0, wraps8 = 0, distinct16 = 0;
    bit   done8 = 0, done16 = 0;

    task automatic drive8(input logic en, input logic ud, input logic ld, input logic [7:0] lv);
        exp_t e;
        int   cur;
        @(negedge clk);
        enable8 = en; up_down8 = ud; load8 = ld; load_value8 = lv;
        e.wrap = 1'b0;
        e.lockup = 1'b0;
        if (ld) begin
            if (lv == 8'hFF) begin
                abs8 = 0;
                e.lockup = 1'b1;
            end else begin
                abs8 = idx8[lv];
            end
            pos8 = 0;
        end else if (en) begin
            cur = seq8[abs8];
            e.wrap = ud ? (cur == 1) : (cur == 8'h80);
            if (ud) begin
                abs8 = (abs8 + p8 - 1) % p8;
                pos8 = (pos8 + p8 - 1) % p8;
            end else begin
                abs8 = (abs8 + 1) % p8;
                pos8 = (pos8 + 1) % p8;
            end
        end
        cur = seq8[abs8];
        e.count    = 16'(cur);
        e.position = 16'(pos8);
        e.overflow = ud ? (cur == 1) : (cur == 8'h80);
        q8.push_back(e);
    endtask

    task automatic drive16(input logic ud);
        exp_t e;
        int   cur;
        @(negedge clk);
        enable16 = 1'b1; up_down16 = ud;
        cur = seq16[abs16];
        e.wrap = ud ? (cur == 1) : (cur == 16'h8000);
        e.lockup = 1'b0;
        if (ud) begin
            abs16 = (abs16 + p16 - 1) % p16;
            pos16 = (pos16 + p16 - 1) % p16;
        end else begin
            abs16 = (abs16 + 1) % p16;
            pos16 = (pos16 + 1) % p16;
        end
        cur = seq16[abs16];
        e.count    = 16'(cur);
        e.position = 16'(pos16);
        e.overflow = ud ? (cur == 1) : (cur == 16'h8000);
        q16.push_back(e);
    endtask

    // ---------------- monitors ----------------
    initial begin
        exp_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (q8.size() > 0) begin
                e = q8.pop_front();
                a.count = 16'(count8); a.position = 16'(position8);
                a.wrap = wrap8; a.lockup = lockup8; a.overflow = overflow8;
                chk_e("dut8_step", a, e);
                if (track8) begin
                    if (!seen8[count8]) begin
                        seen8[count8] = 1'b1;
                        distinct8++;
                    end
                    if (wrap8) wraps8++;
                end
            end
        end
    end

    initial begin
        exp_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (q16.size() > 0) begin
                e = q16.pop_front();
                a.count = count16; a.position = position16;
                a.wrap = wrap16; a.lockup = lockup16; a.overflow = overflow16;
                chk_e("dut16_step", a, e);
                if (track16 && !seen16[count16]) begin
                    seen16[count16] = 1'b1;
                    distinct16++;
                end
            end
        end
    end

    // ---------------- 8-bit stimulus ----------------
    initial begin
        logic [15:0] x;
        for (int i = 0; i < 256; i++) idx8[i] = -1;
        x = 16'h0000;
        p8 = 0;
        do begin
            seq8[p8] = int'(x);
            idx8[x[7:0]] = p8;
            p8++;
            x = nxt(x, 16'h00B1, 8);
        end while (x != 16'h0000 && p8 < 256);
        abs8 = 0;
        pos8 = 0;

        repeat (2) @(negedge clk);
        chk_v("rst8_count", count8, 8'h00);
        chk_v("rst8_position", position8, 8'h00);
        chk_v("rst8_wrap", wrap8, 0);
        chk_v("rst8_lockup", lockup8, 0);
        reset_n8 = 1'b1;

        repeat (3) drive8(1, 0, 0, 8'h00);   // 01, 02, 05
        repeat (3) drive8(1, 1, 0, 8'h00);   // 02, 01, 00 with wrap on the last
        drive8(1, 1, 0, 8'h00);              // 80 / FE
        drive8(1, 0, 0, 8'h00);              // back to 00 / 0 with wrap

        @(posedge clk); #2;
        track8 = 1;
        repeat (255) drive8(1, 0, 0, 8'h00);
        @(posedge clk); #2;
        track8 = 0;
        chk_v("sweep8_distinct", distinct8, 255);
        chk_v("sweep8_wraps", wraps8, 1);

        drive8(0, 0, 1, 8'hFF);              // lock-up load
        drive8(0, 0, 0, 8'h00);
        drive8(1, 0, 1, 8'h3C);              // load beats enable
        drive8(1, 0, 0, 8'h00);

        for (int i = 0; i < 400; i++) begin
            logic [7:0] lv;
            lv = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
            drive8($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                   $urandom_range(0, 9) == 0, lv);
        end

        // Reset asserted between edges must act without a clock.
        drive8(1, 1, 0, 8'h00);
        @(posedge clk); #3;
        reset_n8 = 1'b0;
        enable8 = 1'b0; up_down8 = 1'b0; load8 = 1'b0;
        #1;
        chk_v("midrst8_count", count8, 8'h00);
        chk_v("midrst8_position", position8, 8'h00);
        chk_v("midrst8_wrap", wrap8, 0);
        chk_v("midrst8_lockup", lockup8, 0);
        abs8 = 0;
        pos8 = 0;
        @(negedge clk);
        reset_n8 = 1'b1;

        for (int i = 0; i < 60; i++) drive8(1, 1'($urandom_range(0, 1)), 0, 8'h00);
        @(posedge clk); #2;
        done8 = 1;
    end

    // ---------------- 16-bit stimulus ----------------
    initial begin
        logic [15:0] x;
        x = 16'h0000;
        p16 = 0;
        do begin
            seq16[p16] = int'(x);
            p16++;
            x = nxt(x, 16'hB400, 16);
        end while (x != 16'h0000 && p16 < 65536);
        abs16 = 0;
        pos16 = 0;

        repeat (2) @(negedge clk);
        chk_v("rst16_count", count16, 16'h0000);
        chk_v("rst16_position", position16, 16'h0000);
        reset_n16 = 1'b1;

        @(posedge clk); #2;
        track16 = 1;
        repeat (65535) drive16(1'b0);
        @(posedge clk); #2;
        track16 = 0;
        chk_v("sweep16_distinct", distinct16, 65535);
        chk_v("sweep16_end_count", count16, 16'h0000);

        repeat (3000) drive16(1'b1);
        @(posedge clk); #2;
        done16 = 1;
    end

    // ---------------- end of run ----------------
    initial begin
        wait (done8 && done16);
        @(posedge clk); #3;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: run still active at %0t, required completion", $time);
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/lfsr_updown_param.md
Name: lfsr_updown_param

Overview:
- Parameterised, reversible XNOR LFSR counter.
- Successor to the fixed 8-bit up/down LFSR: arbitrary width and tap mask, parallel load, lock-up recovery, a registered wrap pulse, and a binary position tracker.
- Used as a cheap pseudo-random sequencer / event counter wherever a binary counter's carry chain is too slow.
- Forward and reverse stepping are exact inverses, so the sequence can be rewound.

Parameters:
- WIDTH, 8, LFSR width; legal range 3..32.
- TAPS, 8'b10110001, forward feedback mask (WIDTH bits); bit WIDTH-1 must be 1; maximal-length polynomial expected.
- SEED, 0, reset, recovery and default state (WIDTH bits); must not be all-ones.
- TERM_FWD, 1<<(WIDTH-1), terminal state in forward direction.
- TERM_REV, 1, terminal state in reverse direction.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  advance one step this cycle.
- up_down  in  1  1 = reverse step, 0 = forward step.
- load  in  1  parallel load request.
- load_value  in  WIDTH  value loaded when load=1.
- count  out  WIDTH  LFSR state, registered.
- position  out  WIDTH  steps from last seed/load point, modulo 2^WIDTH-1, registered.
- overflow  out  1  combinational: up_down ? (count==TERM_REV) : (count==TERM_FWD).
- wrap  out  1  registered one-cycle pulse.
- lockup  out  1  registered one-cycle pulse.

Behaviour:
- Reset (reset_n=0, asynchronous, immediate):
  - count=SEED, position=0, wrap=0, lockup=0.
  - Release is sampled at the next rising edge.
- Per-edge priority: load > enable > hold.

Forward step (enable=1, up_down=0):
- count <= {count[W-2:0], ~^(count & TAPS)}.
- position <= (position==2^W-2) ? 0 : position+1.

Reverse step (enable=1, up_down=1):
- count <= {~(count[0] ^ ^(count[W-1:1] & TAPS[W-2:0])), count[W-1:1]}.
- position <= (position==0) ? 2^W-2 : position-1.
- Forward then reverse returns the original count and position exactly.

Load (load=1):
- count <= load_value, position <= 0, regardless of enable.
- If load_value is all-ones (the XNOR lock-up state): count <= SEED instead, and lockup pulses the next cycle.

Lock-up:
- If count is all-ones and enable=1 with load=0: count <= SEED, position <= 0, lockup pulses.
- No forward/reverse step is taken that cycle.

Wrap:
- wrap <= 1 on the edge where a step is taken (enable=1, load=0) while overflow=1; otherwise wrap <= 0.
- Direction change at a terminal state follows the current up_down.

Idle and latency:
- enable=0, load=0: count and position hold; wrap and lockup drop to 0.
- Latency: count/position update 1 cycle after the request. overflow follows count combinationally; wrap/lockup are 1 cycle after the step.

Test Plan:
- Reset, then default params, enable=1, up_down=0 for 3 cycles:
  - count 0x00 -> 0x01 -> 0x02 -> 0x05.
  - position 0 -> 1 -> 2 -> 3.
- From 0x05/pos 3, up_down=1 for 3 cycles:
  - count 0x02, 0x01, 0x00; position 2, 1, 0.
  - wrap pulses after the step taken from 0x01 (overflow=1 at count 0x01).
- At count 0x00/pos 0, reverse one step:
  - count=0x80, position=0xFE.
  - Forward step from 0x80 asserts wrap and returns count 0x00, position 0.
- Run 255 forward steps from reset:
  - Every non-0xFF state is visited exactly once; count returns to 0x00 and position to 0.
  - wrap fires exactly once.
- load=1 with load_value=0xFF:
  - count=0x00, lockup=1 for one cycle.
- load=1 with load_value=0x3C and enable=1 simultaneously:
  - count=0x3C, position=0 (load wins).
- Assert reset_n=0 mid-run between clock edges:
  - count=0x00, position=0, wrap=0 immediately, without a clock edge.
- Repeat the sweep with WIDTH=16, TAPS=16'hB400:
  - 65535 distinct states before returning to SEED.
  - Reverse sweep reproduces the forward sequence backwards.
